sig_sched: RTL

Round-robin scheduler that shares one sig_gen serializer among NUM_REQ requesters. It arbitrates pending requests, latches the winner's message and fires a single-cycle trigger into sig_gen. It then tracks sig_gen's status_out through the transfer and returns a per-requester completion ack, or an error ack if sig_gen never starts. It sits between the requesting blocks and the sig_gen instance, at the same clock.

---
 rtl/sig_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sig_sched.sv
// rtl/sig_sched.sv - round-robin scheduler sharing one sig_gen serializer
// Arbitrates level requests, launches sig_gen, and acks the winner on completion or start timeout.
module sig_sched #(
  parameter int NUM_REQ       = 3,
  parameter int MESSAGE_WIDTH = 16,
  parameter int START_TIMEOUT = 8,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_REQ-1:0]               req_in,
  input  logic [NUM_REQ*MESSAGE_WIDTH-1:0] msg_in,
  output logic [NUM_REQ-1:0]               ack_out,
  output logic                             err_out,
  output logic                             busy_out,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id_out,
  output logic [MESSAGE_WIDTH-1:0]         sig_msg_out,
  output logic                             sig_trigger_out,
  input  logic                             sig_status_in
);
  localparam int GW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW:0]   NUM_REQ_W = (GW + 1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_START, S_WAIT_DONE, S_ACK, S_GAP
  } state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            ptr_q, ptr_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [MESSAGE_WIDTH-1:0] msg_q, msg_d;
  logic                     trig_q, trig_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;

  logic [2*NUM_REQ-1:0]     req_rot;
  logic [GW-1:0]            win_off;
  logic [GW:0]              win_sum;
  logic [GW-1:0]            win_idx;
  logic                     win_valid;
  logic [MESSAGE_WIDTH-1:0] win_msg;

  // Rotate requests so the pointer's index sits at bit 0; the lowest set bit wins.
  always_comb begin
    req_rot   = {req_in, req_in} >> ptr_q;
    win_valid = 1'b0;
    win_off   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        win_valid = 1'b1;
        win_off   = GW'(off);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= NUM_REQ_W) win_sum = win_sum - NUM_REQ_W;
    win_idx = win_sum[GW-1:0];
    win_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) win_msg = msg_in[i*MESSAGE_WIDTH +: MESSAGE_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    trig_d  = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          msg_d   = win_msg;
          trig_d  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        // A start seen on the last allowed cycle still wins over the timeout.
        if (sig_status_in) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          ack_d   = NUM_REQ'(1) << grant_q;
          err_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!sig_status_in) begin
          ack_d   = NUM_REQ'(1) << grant_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        cnt_d   = '0;
        state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      msg_q   <= '0;
      trig_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      trig_q  <= trig_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_out         = ack_q;
  assign err_out         = err_q;
  assign busy_out        = busy_q;
  assign grant_id_out    = grant_q;
  assign sig_msg_out     = msg_q;
  assign sig_trigger_out = trig_q;
endmodule
